// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
// Latency: none (types, constants and helpers only).
// Backpressure: not applicable.
package piso_serializer_pkg;

  // 2-bit state encoding shared with anything that decodes serializer state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Width of a counter that must index 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Serializes handshaked WIDTH-bit words to one bit per cycle with an optional idle gap.
// Latency: word accepted at edge t drives bit 0 at cycle t+1; bits span t+1..t+WIDTH.
// Backpressure: din_ready only in IDLE, on the last bit (no gap) or the last gap cycle.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0,
  parameter bit IDLE_BIT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_data,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int BW      = cnt_width(WIDTH);
  localparam int GW      = cnt_width((GAP_CYCLES > 0) ? GAP_CYCLES : 1);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic             accept;

  // Bit that goes out next from a (possibly partially shifted) word.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Drop the head bit so the following bit becomes the new head.
  function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  // Ready is a pure decode of registered state, forced low while in reset.
  always_comb begin
    din_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE:  din_ready = 1'b1;
        ST_SHIFT: din_ready = !HAS_GAP && (bit_cnt_q == LAST_BIT);
        ST_GAP:   din_ready = (gap_cnt_q == LAST_GAP);
        default:  din_ready = 1'b0;
      endcase
    end
  end

  assign accept = din_valid && din_ready;

  // Next state; the outputs are computed one cycle ahead so they leave the block registered.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    sout_d       = IDLE_BIT;
    sout_valid_d = 1'b0;
    frame_done_d = 1'b0;

    if (accept) begin
      // Ready only exists at word boundaries, so any accept starts a fresh word.
      state_d      = ST_SHIFT;
      shreg_d      = din_data;
      bit_cnt_d    = '0;
      gap_cnt_d    = '0;
      sout_d       = head_bit(din_data);
      sout_valid_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_SHIFT: begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            state_d   = HAS_GAP ? ST_GAP : ST_IDLE;
          end else begin
            shreg_d      = drop_head(shreg_q);
            bit_cnt_d    = bit_cnt_q + 1'b1;
            sout_d       = head_bit(drop_head(shreg_q));
            sout_valid_d = 1'b1;
            frame_done_d = ((bit_cnt_q + 1'b1) == LAST_BIT);
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == LAST_GAP) begin
            gap_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: fall back to the reset picture.
          state_d   = ST_IDLE;
          shreg_d   = '0;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      sout_q       <= IDLE_BIT;
      sout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two configurations driven by directed then random traffic.
// Expected stream is a per-cycle timeline filled from the word-level rules.
// Each cycle compares din_ready, sout, sout_valid, frame_done and busy of both instances.
module tb_piso_serializer;

  localparam int N      = 3200;
  localparam int NCYC   = 3000;
  localparam int RAND_C = 80;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] d0, d1;
  logic       v0, v1;
  logic       r0, r1, s0, s1, sv0, sv1, fd0, fd1, b0, b1;

  // u0: MSB first, no gap, idle low.  u1: LSB first, 2-cycle gap, idle high.
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_BIT(1'b0)) u0 (
    .clk(clk), .rst(rst), .din_data(d0), .din_valid(v0), .din_ready(r0),
    .sout(s0), .sout_valid(sv0), .frame_done(fd0), .busy(b0)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(2), .IDLE_BIT(1'b1)) u1 (
    .clk(clk), .rst(rst), .din_data(d1), .din_valid(v1), .din_ready(r1),
    .sout(s1), .sout_valid(sv1), .frame_done(fd1), .busy(b1)
  );

  int cw[2] = '{8, 8};
  int cg[2] = '{0, 2};
  bit cm[2] = '{1'b1, 1'b0};
  bit ci[2] = '{1'b0, 1'b1};

  // Expected per-cycle picture of each instance.
  bit ev [2][N];
  bit eb [2][N];
  bit ef [2][N];
  bit ebz[2][N];
  int nr [2];   // first cycle from which the instance is ready again

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_from(input int i, input int c);
    for (int j = c; j < N; j++) begin
      ev[i][j]  = 1'b0;
      eb[i][j]  = ci[i];
      ef[i][j]  = 1'b0;
      ebz[i][j] = 1'b0;
    end
  endtask

  // A word accepted in cycle c owns cycles c+1..c+W as data and the next G cycles as gap.
  task automatic fill(input int i, input int c, input logic [31:0] d);
    for (int k = 0; k < cw[i]; k++) begin
      ev[i][c+1+k]  = 1'b1;
      eb[i][c+1+k]  = cm[i] ? d[cw[i]-1-k] : d[k];
      ef[i][c+1+k]  = (k == cw[i] - 1);
      ebz[i][c+1+k] = 1'b1;
    end
    for (int g = 1; g <= cg[i]; g++) begin
      ev[i][c+cw[i]+g]  = 1'b0;
      eb[i][c+cw[i]+g]  = ci[i];
      ef[i][c+cw[i]+g]  = 1'b0;
      ebz[i][c+cw[i]+g] = 1'b1;
    end
  endtask

  initial begin
    bit         vv[2];
    logic [7:0] dd[2];
    logic [4:0] obs[2];
    bit         exp_rdy;

    for (int i = 0; i < 2; i++) begin
      clear_from(i, 0);
      nr[i] = 0;
    end
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;

    for (int c = 0; c < NCYC; c++) begin
      // Stimulus for cycle c.
      rst = (c < 2) || (c == 50) || (c >= RAND_C && $urandom_range(0, 49) == 0);
      if (c == 3)  begin q0.push_back(8'h99); q1.push_back(8'hA5); q1.push_back(8'h3C); end
      if (c == 20) begin q0.push_back(8'hF0); q0.push_back(8'h0F); end
      if (c == 30) q1.push_back(8'h01);
      if (c == 45) begin q0.push_back(8'hFF); q1.push_back(8'hFF); end
      if (c == 55) begin q0.push_back(8'h81); q1.push_back(8'h81); end

      if (c < RAND_C) begin
        vv[0] = (q0.size() != 0);
        vv[1] = (q1.size() != 0);
        dd[0] = vv[0] ? q0[0] : 8'($urandom);
        dd[1] = vv[1] ? q1[0] : 8'($urandom);
      end else begin
        for (int i = 0; i < 2; i++) begin
          vv[i] = ($urandom_range(0, 2) != 0);
          dd[i] = 8'($urandom);
        end
      end
      v0 = vv[0]; d0 = dd[0];
      v1 = vv[1]; d1 = dd[1];
      #1;

      obs[0] = {r0, s0, sv0, fd0, b0};
      obs[1] = {r1, s1, sv1, fd1, b1};

      for (int i = 0; i < 2; i++) begin
        exp_rdy = !rst && (c >= nr[i]);
        chk_eq($sformatf("u%0d.din_ready@%0d", i, c), 32'(obs[i][4]), 32'(exp_rdy));
        if (c >= 1) begin
          chk_eq($sformatf("u%0d.sout@%0d", i, c),       32'(obs[i][3]), 32'(eb[i][c]));
          chk_eq($sformatf("u%0d.sout_valid@%0d", i, c), 32'(obs[i][2]), 32'(ev[i][c]));
          chk_eq($sformatf("u%0d.frame_done@%0d", i, c), 32'(obs[i][1]), 32'(ef[i][c]));
          chk_eq($sformatf("u%0d.busy@%0d", i, c),       32'(obs[i][0]), 32'(ebz[i][c]));
        end

        // Advance the reference with what the edge ending cycle c will do.
        if (rst) begin
          clear_from(i, c + 1);
          nr[i] = c + 1;
        end else if (vv[i] && exp_rdy) begin
          fill(i, c, 32'(dd[i]));
          nr[i] = c + cw[i] + cg[i];
          if (c < RAND_C) begin
            if (i == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
          end
        end
      end

      @(posedge clk);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
